// File: rtl/post_wb_pkg.sv
// Shared types and constants for the post-processing write-back unit.
package post_wb_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/post_wb_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on data_o whenever non-empty.
module post_wb_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/post_writeback.sv
// Write-back unit: buffers the unthrottled post-processed stream and writes it out
// row by row through a ready/valid memory port.
module post_writeback
  import post_wb_pkg::*;
#(
  parameter int unsigned POX        = 3,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DIM_W      = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [ADDR_W-1:0]     row_stride_i,
  input  logic [DIM_W-1:0]      cols_i,
  input  logic [DIM_W-1:0]      rows_i,
  input  logic [POX*DATA_W-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic [ADDR_W-1:0]     wr_addr_o,
  output logic [POX*DATA_W-1:0] wr_data_o,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  localparam int unsigned BeatW  = POX * DATA_W;
  localparam int unsigned CntW   = 2 * DIM_W;
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] stride_q, row_base_q;
  logic [DIM_W-1:0]  cols_q, rows_q, col_q;
  logic [CntW-1:0]   in_cnt_q, out_cnt_q, total;
  logic              ovf_q;

  logic              start_go, fifo_clr, run, take, push, pop, drop, hs, last_col, last_beat;
  logic              fifo_full, fifo_empty;
  logic [BeatW-1:0]  fifo_head;
  logic [CountW-1:0] fifo_count;

  assign total     = CntW'(rows_q) * CntW'(cols_q);
  assign run       = (state_q == StRun);
  assign start_go  = (state_q == StIdle) && start_i;
  assign fifo_clr  = start_go;
  assign wr_valid_o = run && !fifo_empty;
  assign hs        = wr_valid_o && wr_ready_i;
  assign pop       = hs;
  // A beat is wanted only while the layer still owes input beats.
  assign take      = run && in_valid_i && (in_cnt_q < total);
  assign push      = take && (!fifo_full || pop);
  assign drop      = take && fifo_full && !pop;
  assign last_col  = (col_q == cols_q - 1'b1);
  assign last_beat = (out_cnt_q == total - 1'b1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = (rows_i == '0 || cols_i == '0) ? StDone : StRun;
      end
      StRun: begin
        if (hs && last_beat) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      stride_q   <= '0;
      row_base_q <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
      col_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        stride_q   <= row_stride_i;
        row_base_q <= base_addr_i;
        cols_q     <= cols_i;
        rows_q     <= rows_i;
        col_q      <= '0;
        in_cnt_q   <= '0;
        out_cnt_q  <= '0;
        ovf_q      <= 1'b0;
      end else begin
        if (push) in_cnt_q <= in_cnt_q + 1'b1;
        if (drop) ovf_q <= 1'b1;
        if (hs) begin
          out_cnt_q <= out_cnt_q + 1'b1;
          if (last_col) begin
            col_q      <= '0;
            row_base_q <= row_base_q + stride_q;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
      end
    end
  end

  post_wb_fifo #(
    .WIDTH (BeatW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (fifo_clr),
    .push_i  (push),
    .data_i  (in_data_i),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assert property (@(posedge clk_i) disable iff (rst_i) fifo_count <= CountW'(FIFO_DEPTH));

  assign wr_addr_o  = row_base_q + ADDR_W'(col_q);
  // Gate the head so the data port reads zero when nothing is offered.
  assign wr_data_o  = wr_valid_o ? fifo_head : '0;
  assign busy_o     = run;
  assign done_o     = (state_q == StDone);
  assign overflow_o = ovf_q;

endmodule
